// File: rtl/sgd_bw_pkg.sv
// sgd_bw_pkg: shared constants and types for the bit-plane SGD engine.
//   NUM_OF_BANKS samples per group, NUM_BITS_PER_BANK features per A-word bank,
//   accumulator widths, the engine state enum and the 64-word model/gradient row.
package sgd_bw_pkg;
  localparam int NUM_OF_BANKS      = 8;
  localparam int NUM_BITS_PER_BANK = 64;
  localparam int DOT_W             = 64;
  localparam int ERR_W             = 32;
  localparam int GRAD_W            = 32;
  localparam int X_W               = 32;
  localparam int NUM_STATES        = 8;

  // Encoding doubles as the state-counter slot index.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FWD    = 3'd1,
    S_TX     = 3'd2,
    S_RX     = 3'd3,
    S_BWD    = 3'd4,
    S_UPDATE = 3'd5,
    S_SEND_X = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  // One RAM row: 64 consecutive 32-bit words, word 0 in the low bits.
  typedef logic [NUM_BITS_PER_BANK-1:0][X_W-1:0] row_t;
endpackage

// File: rtl/sgd_bw_fifo.sv
// sgd_bw_fifo: synchronous show-ahead FIFO.
//   clk, rst (sync, active high: flushes contents)
//   wr_en/wr_data : push; dropped when full
//   rd_en/rd_data : pop; rd_data always shows the head entry
//   empty         : no entries
//   almost_full   : free entries <= AF_FREE
module sgd_bw_fifo #(
  parameter int WIDTH   = 512,
  parameter int DEPTH   = 64,
  parameter int AF_FREE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             almost_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;
  logic             wr_ok, rd_ok;

  assign wr_ok       = wr_en && (cnt != (AW+1)'(DEPTH));
  assign rd_ok       = rd_en && (cnt != '0);
  assign empty       = (cnt == '0);
  assign almost_full = (cnt >= (AW+1)'(DEPTH - AF_FREE));
  assign rd_data     = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= wr_data;
  end
endmodule

// File: rtl/sgd_bw_core.sv
// sgd_bw_core: single-node SGD engine for linear regression on bit-plane samples.
//   clk, rst (sync, active high)          start_um / run config (sampled at start)
//   m_axis_tx_data_*  : 8 x 64-bit partial dots out, held until ready
//   s_axis_rx_data_*  : aggregated dots in, no backpressure
//   dispatch_axb_a_*  : A FIFO (8 banks x 64 feature bits per word)
//   dispatch_axb_b_*  : B FIFO (8 x 32-bit labels per word)
//   x_data_*          : model stream after every epoch
//   um_done, um_state_counters
// Optional: define SGD_STATE_COUNTERS_EN to build the per-state cycle counters;
// otherwise um_state_counters is tied to 0.
module sgd_bw_core
  import sgd_bw_pkg::*;
#(
  parameter int DATA_WIDTH_IN      = 4,
  parameter int MAX_DIMENSION_BITS = 18,
  parameter int A_FIFO_DEPTH       = 64,
  parameter int B_FIFO_DEPTH       = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_um,
  input  logic [31:0]  mini_batch_size,
  input  logic [31:0]  step_size,
  input  logic [31:0]  number_of_epochs,
  input  logic [31:0]  dimension,
  input  logic [31:0]  number_of_samples,
  input  logic [31:0]  number_of_bits,
  output logic         um_done,
  output logic [255:0] um_state_counters,
  output logic [511:0] m_axis_tx_data_data,
  output logic [63:0]  m_axis_tx_data_keep,
  output logic         m_axis_tx_data_last,
  output logic         m_axis_tx_data_valid,
  input  logic         m_axis_tx_data_ready,
  input  logic [511:0] s_axis_rx_data_data,
  input  logic [63:0]  s_axis_rx_data_keep,
  input  logic         s_axis_rx_data_last,
  input  logic         s_axis_rx_data_valid,
  input  logic [511:0] dispatch_axb_a_data,
  input  logic         dispatch_axb_a_wr_en,
  output logic         dispatch_axb_a_almost_full,
  input  logic [255:0] dispatch_axb_b_data,
  input  logic         dispatch_axb_b_wr_en,
  output logic         dispatch_axb_b_almost_full,
  output logic         x_data_send_back_start,
  output logic [31:0]  x_data_send_back_length,
  output logic [511:0] x_data_out,
  output logic         x_data_out_valid,
  input  logic         x_data_out_almost_full
);
  localparam int ROWS = (2**MAX_DIMENSION_BITS) / NUM_BITS_PER_BANK;
  localparam int RW   = MAX_DIMENSION_BITS - 6;
  localparam int KW   = $clog2(DATA_WIDTH_IN + 1);

  state_t state_q, state_d;

  // run config
  logic [31:0] cfg_mb, cfg_step, cfg_ep, cfg_rows, cfg_groups, cfg_nb, len_q;

  // sequencing
  logic [KW-1:0] k_cnt;
  logic [31:0]   c_cnt, grp_cnt, mb_cnt, ep_cnt, beat_cnt;
  logic          ep_end_q, send_phase, rx_pend;

  // datapath state
  logic [NUM_OF_BANKS-1:0][DOT_W-1:0] dot_q, dot_nxt, dot_fin;
  logic [NUM_OF_BANKS-1:0][ERR_W-1:0] err_q, rx_lo, rx_hi, rx_buf;
  row_t                               x_mem [ROWS];
  row_t                               g_mem [ROWS];
  logic [ROWS-1:0]                    x_vld, g_vld;
  row_t                               x_row, g_row, g_new, x_new;
  logic [RW-1:0]                      rd_row;

  logic [511:0] a_word;
  logic [255:0] b_word;
  logic         a_empty, b_empty, a_pop, b_pop;
  logic         last_plane, last_row, last_word, grp_last, mb_hit, send_done;
  logic [31:0]  mb_nxt, sh, total_beats;
  logic [63:0]  fsum;
  logic [31:0]  gsum;

  sgd_bw_fifo #(.WIDTH(512), .DEPTH(A_FIFO_DEPTH), .AF_FREE(4)) u_a_fifo (
    .clk(clk), .rst(rst),
    .wr_en(dispatch_axb_a_wr_en), .wr_data(dispatch_axb_a_data),
    .rd_en(a_pop), .rd_data(a_word),
    .empty(a_empty), .almost_full(dispatch_axb_a_almost_full)
  );

  sgd_bw_fifo #(.WIDTH(256), .DEPTH(B_FIFO_DEPTH), .AF_FREE(4)) u_b_fifo (
    .clk(clk), .rst(rst),
    .wr_en(dispatch_axb_b_wr_en), .wr_data(dispatch_axb_b_data),
    .rd_en(b_pop), .rd_data(b_word),
    .empty(b_empty), .almost_full(dispatch_axb_b_almost_full)
  );

  // ---------------- control terms ----------------
  assign last_plane  = (32'(k_cnt) == cfg_nb - 32'd1);
  assign last_row    = (c_cnt == cfg_rows - 32'd1);
  assign last_word   = last_plane && last_row;
  assign grp_last    = (grp_cnt == cfg_groups - 32'd1);
  assign mb_nxt      = mb_cnt + 32'd8;
  assign mb_hit      = (mb_nxt >= cfg_mb);
  assign total_beats = {cfg_rows[29:0], 2'b00};
  assign sh          = cfg_nb - 32'd1 - 32'(k_cnt);
  assign a_pop       = ((state_q == S_FWD) || (state_q == S_BWD)) && !a_empty;
  assign b_pop       = (state_q == S_RX) && rx_pend && !b_empty;
  assign send_done   = (state_q == S_SEND_X) && send_phase && (beat_cnt == total_beats);

  // Every row-addressed access goes through one read port; SEND_X walks
  // the rows four beats at a time, everything else follows c_cnt.
  assign rd_row = (state_q == S_SEND_X) ? beat_cnt[RW+1:2] : c_cnt[RW-1:0];
  // Valid bits stand in for clearing whole RAMs: an invalid row reads as zero.
  assign x_row  = x_vld[rd_row] ? x_mem[rd_row] : '0;
  assign g_row  = g_vld[rd_row] ? g_mem[rd_row] : '0;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_um) state_d = S_FWD;
      S_FWD:    if (a_pop && last_word) state_d = S_TX;
      S_TX:     if (m_axis_tx_data_ready) state_d = S_RX;
      S_RX:     if (b_pop) state_d = S_BWD;
      S_BWD:    if (a_pop && last_word) state_d = (mb_hit || grp_last) ? S_UPDATE : S_FWD;
      S_UPDATE: if (last_row) state_d = ep_end_q ? S_SEND_X : S_FWD;
      S_SEND_X: if (send_done) state_d = (ep_cnt + 32'd1 >= cfg_ep) ? S_DONE : S_FWD;
      S_DONE:   if (!start_um) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- arithmetic ----------------
  always_comb begin
    fsum    = '0;
    gsum    = '0;
    dot_nxt = dot_q;
    dot_fin = dot_q;
    g_new   = g_row;
    x_new   = x_row;
    rx_lo   = '0;
    rx_hi   = '0;
    for (int s = 0; s < NUM_OF_BANKS; s++) begin
      fsum = '0;
      for (int j = 0; j < NUM_BITS_PER_BANK; j++)
        if (a_word[s*NUM_BITS_PER_BANK + j]) fsum = fsum + {{32{x_row[j][31]}}, x_row[j]};
      dot_nxt[s] = dot_q[s] + (fsum << sh);
      // The final plane folds in the 1/2^nb scale of the quantized features.
      dot_fin[s] = last_word ? 64'($signed(dot_nxt[s]) >>> cfg_nb) : dot_nxt[s];
      rx_lo[s]   = s_axis_rx_data_data[s*64 +: 32];
      rx_hi[s]   = s_axis_rx_data_data[s*64 + 32 +: 32];
    end
    for (int j = 0; j < NUM_BITS_PER_BANK; j++) begin
      gsum = '0;
      for (int s = 0; s < NUM_OF_BANKS; s++)
        if (a_word[s*NUM_BITS_PER_BANK + j]) gsum = gsum + err_q[s];
      g_new[j] = g_row[j] + (gsum << sh);
      x_new[j] = x_row[j] - 32'($signed(g_row[j]) >>> (cfg_step + cfg_nb));
    end
  end

  // ---------------- sequencing / datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_mb <= '0; cfg_step <= '0; cfg_ep <= '0; cfg_rows <= '0;
      cfg_groups <= '0; cfg_nb <= '0; len_q <= '0;
      k_cnt <= '0; c_cnt <= '0; grp_cnt <= '0; mb_cnt <= '0; ep_cnt <= '0; beat_cnt <= '0;
      ep_end_q <= 1'b0; send_phase <= 1'b0; rx_pend <= 1'b0;
      dot_q <= '0; err_q <= '0; rx_buf <= '0;
      x_vld <= '0; g_vld <= '0;
      x_data_send_back_start <= 1'b0;
      x_data_out_valid <= 1'b0;
      x_data_out <= '0;
    end else begin
      x_data_send_back_start <= 1'b0;
      x_data_out_valid       <= 1'b0;

      // The network cannot be stalled, so a beat is parked until RX consumes it.
      if (s_axis_rx_data_valid) begin
        rx_buf  <= rx_lo;
        rx_pend <= 1'b1;
      end else if (b_pop) begin
        rx_pend <= 1'b0;
      end

      case (state_q)
        S_IDLE: if (start_um) begin
          cfg_mb     <= mini_batch_size;
          cfg_step   <= step_size;
          cfg_ep     <= number_of_epochs;
          cfg_rows   <= {6'd0, dimension[31:6]};
          cfg_groups <= {3'd0, number_of_samples[31:3]};
          cfg_nb     <= number_of_bits;
          len_q      <= {dimension[29:0], 2'b00};
          k_cnt <= '0; c_cnt <= '0; grp_cnt <= '0; mb_cnt <= '0; ep_cnt <= '0; beat_cnt <= '0;
          ep_end_q <= 1'b0; send_phase <= 1'b0;
          dot_q <= '0; err_q <= '0;
          x_vld <= '0; g_vld <= '0;
        end
        S_FWD: if (a_pop) begin
          dot_q <= dot_fin;
          if (last_plane) begin
            k_cnt <= '0;
            c_cnt <= last_row ? 32'd0 : c_cnt + 32'd1;
          end else k_cnt <= k_cnt + 1'b1;
        end
        S_TX: if (m_axis_tx_data_ready) dot_q <= '0;
        S_RX: if (b_pop) begin
          for (int s = 0; s < NUM_OF_BANKS; s++)
            err_q[s] <= rx_buf[s] - b_word[s*32 +: 32];
        end
        S_BWD: if (a_pop) begin
          g_vld[rd_row] <= 1'b1;
          if (last_plane) begin
            k_cnt <= '0;
            c_cnt <= last_row ? 32'd0 : c_cnt + 32'd1;
          end else k_cnt <= k_cnt + 1'b1;
          if (last_word) begin
            grp_cnt  <= grp_last ? 32'd0 : grp_cnt + 32'd1;
            ep_end_q <= grp_last;
            mb_cnt   <= (mb_hit || grp_last) ? 32'd0 : mb_nxt;
          end
        end
        S_UPDATE: begin
          x_vld[rd_row] <= 1'b1;
          g_vld[rd_row] <= 1'b0;
          c_cnt <= last_row ? 32'd0 : c_cnt + 32'd1;
        end
        S_SEND_X: begin
          if (!send_phase) begin
            x_data_send_back_start <= 1'b1;
            send_phase <= 1'b1;
            beat_cnt   <= '0;
          end else if (send_done) begin
            send_phase <= 1'b0;
            ep_cnt     <= ep_cnt + 32'd1;
          end else if (!x_data_out_almost_full) begin
            x_data_out       <= x_row[{beat_cnt[1:0], 4'b0000} +: 16];
            x_data_out_valid <= 1'b1;
            beat_cnt         <= beat_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Gradient RMW reads and writes the same row in one cycle, so a following
  // word for that row always sees the freshly written value.
  always_ff @(posedge clk) begin
    if ((state_q == S_BWD) && a_pop) g_mem[rd_row] <= g_new;
    if (state_q == S_UPDATE)          x_mem[rd_row] <= x_new;
  end

  // ---------------- outputs ----------------
  assign m_axis_tx_data_valid    = (state_q == S_TX);
  assign m_axis_tx_data_data     = dot_q;
  assign m_axis_tx_data_keep     = {64{state_q == S_TX}};
  assign m_axis_tx_data_last     = (state_q == S_TX);
  assign um_done                 = (state_q == S_DONE);
  assign x_data_send_back_length = len_q;

`ifdef SGD_STATE_COUNTERS_EN
  logic [NUM_STATES-1:0][31:0] st_cnt;
  always_ff @(posedge clk) begin
    if (rst)                                st_cnt <= '0;
    else if ((state_q == S_IDLE) && start_um) st_cnt <= '0;
    else if (st_cnt[state_q] != '1)         st_cnt[state_q] <= st_cnt[state_q] + 32'd1;
  end
  assign um_state_counters = st_cnt;
`else
  assign um_state_counters = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{rx_hi, s_axis_rx_data_keep, s_axis_rx_data_last,
                         c_cnt[31:RW], beat_cnt[31:RW+2],
                         dimension[31:30], number_of_samples[2:0]};
endmodule

// File: tb/tb_sgd_bw_core.sv
// tb_sgd_bw_core: directed bench for sgd_bw_core. The tx stream is looped back
// into rx one cycle later; a dispatcher model feeds both FIFOs from queues,
// reacting to almost_full one cycle late.
module tb_sgd_bw_core;
  logic         clk = 1'b0;
  logic         rst, start_um;
  logic [31:0]  mini_batch_size, step_size, number_of_epochs, dimension, number_of_samples, number_of_bits;
  logic         um_done;
  logic [255:0] um_state_counters;
  logic [511:0] tx_data;
  logic [63:0]  tx_keep;
  logic         tx_last, tx_valid, tx_ready;
  logic [511:0] rx_data;
  logic         rx_valid;
  logic [63:0]  rx_keep;
  logic         rx_last;
  logic [511:0] a_data;
  logic         a_wr, a_af;
  logic [255:0] b_data;
  logic         b_wr, b_af;
  logic         sb_start;
  logic [31:0]  sb_len;
  logic [511:0] x_out;
  logic         x_valid, x_af;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sgd_bw_core dut (
    .clk(clk), .rst(rst), .start_um(start_um),
    .mini_batch_size(mini_batch_size), .step_size(step_size),
    .number_of_epochs(number_of_epochs), .dimension(dimension),
    .number_of_samples(number_of_samples), .number_of_bits(number_of_bits),
    .um_done(um_done), .um_state_counters(um_state_counters),
    .m_axis_tx_data_data(tx_data), .m_axis_tx_data_keep(tx_keep),
    .m_axis_tx_data_last(tx_last), .m_axis_tx_data_valid(tx_valid),
    .m_axis_tx_data_ready(tx_ready),
    .s_axis_rx_data_data(rx_data), .s_axis_rx_data_keep(rx_keep),
    .s_axis_rx_data_last(rx_last), .s_axis_rx_data_valid(rx_valid),
    .dispatch_axb_a_data(a_data), .dispatch_axb_a_wr_en(a_wr),
    .dispatch_axb_a_almost_full(a_af),
    .dispatch_axb_b_data(b_data), .dispatch_axb_b_wr_en(b_wr),
    .dispatch_axb_b_almost_full(b_af),
    .x_data_send_back_start(sb_start), .x_data_send_back_length(sb_len),
    .x_data_out(x_out), .x_data_out_valid(x_valid),
    .x_data_out_almost_full(x_af)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // loopback network
  assign rx_keep = '1;
  assign rx_last = 1'b1;
  always @(posedge clk) begin
    if (rst) rx_valid <= 1'b0;
    else begin
      rx_valid <= tx_valid && tx_ready;
      rx_data  <= tx_data;
    end
  end

  // dispatcher model
  logic [511:0] a_q[$];
  logic [255:0] b_q[$];
  bit   feed_en = 0;
  logic a_af_d = 1'b0, b_af_d = 1'b0;
  bit   saw_a_af = 0, saw_b_af = 0;
  initial begin
    a_wr = 1'b0; b_wr = 1'b0; a_data = '0; b_data = '0;
    forever begin
      @(posedge clk); #1;
      a_wr = 1'b0; b_wr = 1'b0;
      if (feed_en && !rst && !a_af_d && a_q.size() > 0) begin a_data = a_q.pop_front(); a_wr = 1'b1; end
      if (feed_en && !rst && !b_af_d && b_q.size() > 0) begin b_data = b_q.pop_front(); b_wr = 1'b1; end
      a_af_d = a_af; b_af_d = b_af;
      if (a_af) saw_a_af = 1;
      if (b_af) saw_b_af = 1;
    end
  end

  // output monitors
  logic [511:0] tx_q[$];
  logic [511:0] x_q[$];
  logic [511:0] tx_or;
  logic [63:0]  seen_keep;
  logic         seen_last;
  int           start_cnt;
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      tx_q.push_back(tx_data); tx_or = tx_or | tx_data;
      seen_keep = tx_keep; seen_last = tx_last;
    end
    if (!rst && x_valid) x_q.push_back(x_out);
    if (!rst && sb_start) start_cnt++;
  end

  initial begin
    #(500000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [511:0] ONES  = '1;
  localparam logic [255:0] BWORD = {8{32'd256}};
  localparam logic [511:0] X400  = {16{32'h0000_0400}};
  localparam logic [511:0] XA000 = {16{32'h0000_A000}};
  localparam logic [511:0] XEP2  = {16{32'hFFFE_0800}};  // -129024
  localparam logic [511:0] DOT2  = {8{64'd32768}};

  task automatic set_cfg(input int d, input int n, input int nb, input int mb, input int st, input int ep);
    dimension = d; number_of_samples = n; number_of_bits = nb;
    mini_batch_size = mb; step_size = st; number_of_epochs = ep;
  endtask

  task automatic clear_mon();
    tx_q.delete(); x_q.delete(); tx_or = '0; start_cnt = 0;
    seen_keep = '0; seen_last = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    for (int i = 0; i < limit && !um_done; i++) @(negedge clk);
    @(negedge clk);
    check(tag, um_done, 1);
  endtask

  task automatic finish_run();
    @(posedge clk); #1 start_um = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int bad;
    rst = 1'b1; start_um = 1'b0; tx_ready = 1'b1; x_af = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    clear_mon();

    // reset state
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_done", um_done, 0);
    check("rst_a_af", a_af, 0);
    check("rst_b_af", b_af, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_x_valid", x_valid, 0);
    check("rst_sb_start", sb_start, 0);
    check("rst_sb_len", sb_len, 0);
    check("rst_counters", um_state_counters, 0);
    @(posedge clk); #1 rst = 1'b0;

    // scenario 1: one epoch, one group
    set_cfg(64, 8, 1, 8, 0, 1);
    a_q.push_back(ONES); a_q.push_back(ONES); b_q.push_back(BWORD);
    feed_en = 1;
    repeat (4) @(posedge clk); #1 start_um = 1'b1;
    wait_done(2000, "s1_done");
    check("s1_tx_count", tx_q.size(), 1);
    check("s1_tx_beat", tx_q[0], 0);
    check("s1_tx_keep", seen_keep, 64'hFFFF_FFFF_FFFF_FFFF);
    check("s1_tx_last", seen_last, 1);
    check("s1_x_count", x_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("s1_x_beat%0d", i), x_q[i], X400);
    check("s1_sb_len", sb_len, 256);
    check("s1_sb_start_pulses", start_cnt, 1);
    finish_run();
    check("s1_done_cleared", um_done, 0);

    // scenario 2: two epochs, second tx beat held back for 100 cycles
    clear_mon();
    set_cfg(64, 8, 1, 8, 0, 2);
    repeat (2) begin a_q.push_back(ONES); a_q.push_back(ONES); b_q.push_back(BWORD); end
    repeat (4) @(posedge clk); #1 start_um = 1'b1;
    for (int i = 0; i < 3000 && tx_q.size() < 1; i++) @(negedge clk);
    check("s2_first_tx", tx_q.size(), 1);
    @(posedge clk); #1 tx_ready = 1'b0;
    for (int i = 0; i < 3000 && !tx_valid; i++) @(negedge clk);
    check("s2_tx_pending", tx_valid, 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== DOT2) bad++;
    end
    check("s2_hold_stable", bad, 0);
    check("s2_hold_data", tx_data, DOT2);
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_done(3000, "s2_done");
    check("s2_tx_count", tx_q.size(), 2);
    check("s2_tx_beat1", tx_q[1], DOT2);
    check("s2_x_count", x_q.size(), 8);
    check("s2_x_ep1", x_q[3], X400);
    check("s2_x_ep2_first", x_q[4], XEP2);
    check("s2_x_ep2_last", x_q[7], XEP2);
    check("s2_sb_start_pulses", start_cnt, 2);
    finish_run();

    // scenario 3: 40 groups, engine stalled so both FIFOs reach almost_full
    clear_mon();
    saw_a_af = 0; saw_b_af = 0;
    set_cfg(64, 320, 1, 320, 0, 1);
    tx_ready = 1'b0;
    repeat (40) begin a_q.push_back(ONES); a_q.push_back(ONES); b_q.push_back(BWORD); end
    @(posedge clk); #1 start_um = 1'b1;
    repeat (300) @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_done(20000, "s3_done");
    check("s3_saw_a_af", saw_a_af, 1);
    check("s3_saw_b_af", saw_b_af, 1);
    check("s3_a_drained", a_q.size(), 0);
    check("s3_tx_count", tx_q.size(), 40);
    check("s3_tx_all_zero", tx_or, 0);
    check("s3_x_count", x_q.size(), 4);
    check("s3_x_beat0", x_q[0], XA000);
    check("s3_x_beat3", x_q[3], XA000);
    finish_run();

    // scenario 4: reset while BWD waits for its A word, then a clean rerun
    clear_mon();
    set_cfg(64, 8, 1, 8, 0, 1);
    a_q.push_back(ONES); b_q.push_back(BWORD);
    repeat (4) @(posedge clk); #1 start_um = 1'b1;
    for (int i = 0; i < 2000 && tx_q.size() < 1; i++) @(negedge clk);
    check("s4_pre_tx", tx_q.size(), 1);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1; start_um = 1'b0; feed_en = 0;
    a_q.delete(); b_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("s4_rst_done", um_done, 0);
    check("s4_rst_tx_valid", tx_valid, 0);
    check("s4_rst_sb_len", sb_len, 0);
    @(posedge clk); #1 rst = 1'b0;
    clear_mon();
    a_q.push_back(ONES); a_q.push_back(ONES); b_q.push_back(BWORD);
    feed_en = 1;
    repeat (4) @(posedge clk); #1 start_um = 1'b1;
    wait_done(2000, "s4_done");
    check("s4_tx_count", tx_q.size(), 1);
    check("s4_tx_beat", tx_q[0], 0);
    check("s4_x_count", x_q.size(), 4);
    check("s4_x_beat0", x_q[0], X400);
    check("s4_x_beat3", x_q[3], X400);
    check("s4_sb_len", sb_len, 256);
    finish_run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sgd_bw_core.md
Name: sgd_bw_core

Overview:
Single-node stochastic gradient descent (SGD) training engine for linear regression on bit-plane-quantized samples.
- Consumes sample bit-planes from dispatch FIFO ports, computes per-sample dot products against an on-chip model, and exchanges partial dots over an AXI-stream network pair.
- Forms errors against labels, accumulates mini-batch gradients, updates the model, and streams the model out after every epoch.
- Sits between the HBM dispatcher and the network stack.

Parameters:
DATA_WIDTH_IN, 4: maximum bit-planes per feature (number_of_bits ≤ this).
MAX_DIMENSION_BITS, 18: log2 of maximum dimension; sizes model and gradient RAMs (depth 2^MAX_DIMENSION_BITS/64, width 2048).
A_FIFO_DEPTH, 64: input A FIFO depth (power of 2).
B_FIFO_DEPTH, 16: input B FIFO depth (power of 2).

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
start_um  in  1  level; a run starts when high in IDLE
mini_batch_size/step_size/number_of_epochs/dimension/number_of_samples/number_of_bits  in  32 each  run config; sampled when a run starts
um_done  out  1  high in DONE
um_state_counters  out  256  8×32 per-state cycle counters (optional feature)
m_axis_tx_data_data/_keep/_last/_valid  out  512/64/1/1  partial-dot beat
m_axis_tx_data_ready  in  1  tx backpressure
s_axis_rx_data_data/_keep/_last/_valid  in  512/64/1/1  aggregated-dot beat; no ready, must be accepted when it arrives
dispatch_axb_a_data  in  512  8 banks × 64 feature bits
dispatch_axb_a_wr_en  in  1  A FIFO write
dispatch_axb_a_almost_full  out  1  A FIFO free entries ≤ 4
dispatch_axb_b_data  in  256  8 × 32-bit signed labels
dispatch_axb_b_wr_en  in  1  B FIFO write
dispatch_axb_b_almost_full  out  1  B FIFO free entries ≤ 4
x_data_send_back_start  out  1  one-cycle pulse before model stream
x_data_send_back_length  out  32  model bytes = dimension×4
x_data_out  out  512  16 × 32-bit model words, lowest index in bits [31:0]
x_data_out_valid  out  1  model beat valid
x_data_out_almost_full  in  1  when high, model stream stalls

Behaviour:
Constraints on config:
- dimension is a multiple of 64; number_of_samples and mini_batch_size are multiples of 8; 1 ≤ number_of_bits ≤ DATA_WIDTH_IN.
- Writes to a full FIFO are dropped; the writer must honour almost_full.

Data format and dispatcher contract:
- Group = 8 samples, one per bank; bank s occupies bits [64s+63:64s].
- A-word order per pass: for chunk c = 0..D/64-1, for plane k = 0..nb-1 (MSB first), one word.
- The dispatcher sends each group's A words twice, forward then backward. One B word per group.
- Model x: 32-bit signed, reset to 0 at run start.

State machine: IDLE → FWD → TX → RX → BWD → (UPDATE) → next group, or SEND_X at epoch end → next epoch or DONE.
- FWD: pop one A word per cycle when the A FIFO is non-empty. Accumulate dot[s] += Σ_j bit[s][j]·x[j] << (nb-1-k), 64-bit signed. After the last word, dot[s] = dot[s] >>> nb.
- TX: data = 8 × 64-bit dot (sample s at bits [64s+63:64s]), keep = all 1s, last = 1. valid is held with data stable until ready.
- RX: wait for rx valid and a non-empty B FIFO; pop B. err[s] = rx_dot[s][31:0] − b[s], 32-bit signed, wraps.
- BWD: per word, grad[j] += Σ_s bit[s][j]·err[s] << (nb-1-k), 32-bit wrapping. Gradient RAM read-modify-write must be hazard-free for back-to-back words.
- UPDATE: entered when mini_batch_size samples have been seen since the last update, or at epoch end. One 64-entry row per cycle: x[j] −= grad[j] >>> (step_size+nb); grad[j] = 0.
- SEND_X: pulse send_back_start, then D/16 beats gated by ~x_data_out_almost_full.
- DONE: um_done = 1; return to IDLE when start_um = 0.

Reset values:
- All outputs 0 in reset; both FIFOs flushed; state IDLE.
- Counters, dot, err, grad and x are cleared.
- Reset mid-run aborts immediately.

Optional Feature:
- SGD_STATE_COUNTERS_EN defined: um_state_counters[32i+31:32i] counts cycles spent in state i (IDLE=0 … DONE=7). Counters clear on run start and saturate at all-ones.
- Undefined: um_state_counters is tied to 0 and no counter logic is built.

Decomposition:
- Package sgd_bw_pkg: NUM_OF_BANKS=8, NUM_BITS_PER_BANK=64, state enum, dot/err/grad width constants.
- Sub-module sgd_bw_fifo: synchronous FIFO with an almost_full threshold parameter, instantiated for A and B.

Test Plan:
- Reset held 10 cycles → all outputs 0, both almost_full 0, um_done 0.
- D=64, N=8, nb=1, mb=8, step=0, epochs=1, all A bits 1, b=256, tx looped to rx → tx beat all zeros; x_data_out = 4 beats of 16×0x00000400; send_back_length = 256; um_done = 1.
- Same config, epochs=2 → second-epoch tx beat = 8×32768; final x = 1024 − ((8×(32768−256)) >>> 1) = −129024.
- Hold m_axis_tx_data_ready low for 100 cycles in TX → valid stays 1 and data is stable; the run completes correctly after release.
- Writer asserts wr_en whenever almost_full is low, with a 1-cycle registered delay, and the engine stalls → no FIFO overflow and results match the unstalled run.
- Assert rst during BWD, then rerun the first scenario → identical results to a fresh run.
